addsub_arb: RTL and testbench
=============================

Name: addsub_arb

Overview:
- Shares the single add unit (command 1) and sub unit (command 2) between two requesters, e.g. the main instruction sequencer and the index-register/address path.
- Round-robin arbiter plus a sequencer for the start/stop handshake.
- Holds operands stable for the unit's whole busy window, captures result and overflow, and returns them to the owner with a one-cycle done pulse.
- Words are 31-bit sign-magnitude: bit 30 is the sign, bits 29:0 are the magnitude.

Parameters:
- TIMEOUT, 15, WAIT cycles without a unit stop before the operation is aborted with err.
- CW, 4, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request valid from requester 0 / 1.
- op0 / op1  in  1  0 = add, 1 = sub (result is a minus b).
- a0, b0 / a1, b1  in  31 each  operands; sampled only on acceptance.
- gnt0 / gnt1  out  1  ready; combinational; request accepted on an edge where req_x and gnt_x are both 1.
- done0 / done1  out  1  one-cycle result pulse to the owner.
- res  out  31  result word, held until the next done.
- ovf  out  1  overflow flag, held until the next done.
- err  out  1  timeout flag, held until the next done.
- busy  out  1  high in every state except IDLE.
- add_start / sub_start  out  1  start strobe to the add / sub unit.
- u_in1, u_in2  out  31  shared operand buses to both units.
- add_stop, add_out, add_ovf  in  1/31/1  add unit response.
- sub_stop, sub_out, sub_ovf  in  1/31/1  sub unit response.

Behaviour:
Reset (async, rst_n=0):
- State = IDLE; priority pointer = 0.
- Starts, done0/1, res, ovf, err, busy, u_in1, u_in2 and the timeout counter all 0.

States:
- IDLE
  - gnt0 = 1 if req0 and (pri==0 or !req1).
  - gnt1 = 1 if req1 and (pri==1 or !req0).
  - At most one gnt high; both gnt are 0 outside IDLE.
  - On acceptance: latch owner, op, u_in1 = a_x, u_in2 = b_x; go to ISSUE.
- ISSUE (one cycle)
  - Assert exactly one of add_start / sub_start, selected by latched op. Go to WAIT.
- WAIT
  - Starts 0; u_in1 and u_in2 held unchanged (the unit samples in2 combinationally during its stop cycle).
  - Selected stop = 1: capture selected out into res, selected ovf into ovf, err = 0; go to DONE.
  - Otherwise increment the counter; counter == TIMEOUT-1 with no stop: res = 0, ovf = 0, err = 1; go to DONE.
  - The stop of the unselected unit is ignored.
- DONE (one cycle)
  - done_owner = 1; pri = ~owner; counter cleared; go to IDLE.

Latency:
- Accept edge E0, start high in cycle E0..E1, stop high in cycle E1..E2, done high in cycle E2..E3.
- Done is high 3 cycles after the acceptance cycle. New acceptance is possible in the cycle after DONE.
- Throughput: one operation per 4 cycles.

Boundary rules:
- Requests raised while busy are not accepted. The requester keeps req and operands until it sees gnt.
- Simultaneous requests: pri decides; pri flips after each completion. Strict alternation under continuous load from both.
- res / ovf are passed through unmodified, including minus zero and a sign-magnitude result with magnitude 0.
- Reset asserted mid-operation aborts silently: no done, unit start dropped immediately. A late stop from the aborted op is ignored because the state is IDLE.

Decomposition:
- Shared package:
  - Word width 31 and sign-bit index 30.
  - State encoding IDLE=0, ISSUE=1, WAIT=2, DONE=3.
  - op encoding OP_ADD=0, OP_SUB=1.
- Natural sub-module: rr_arb2, the two-way round-robin grant logic with priority flip on completion. Everything else stays in addsub_arb.
- The add/sub units themselves are instantiated by the parent, not inside this block.

Test Plan:
- Single sub: req0 with op0=1, a0=5, b0=3 → sub_start pulse one cycle after acceptance; done0 3 cycles after acceptance; res=0x00000002, ovf=0, err=0.
- Add overflow: req1 with op1=0, a1=0x3FFFFFFF, b1=0x00000001 → done1; res=0x00000000, ovf=1; add_start pulsed, sub_start never.
- Mixed signs: sub, a=0x40000005 (−5), b=0x00000003 → res=0x40000008, ovf=0. u_in2 is stable from ISSUE through the stop cycle.
- Arbitration: req0 and req1 held high continuously → grant order 0,1,0,1. Accept cycles exactly 4 apart; done0 and done1 never high together.
- Timeout: add_stop and sub_stop tied 0, one request → done after 2+TIMEOUT cycles with err=1, res=0, ovf=0. The next request completes normally with err=0.
- Reset in WAIT: rst_n pulled low in the WAIT cycle → busy, starts and done drop to 0 asynchronously. After release, gnt0 is first on simultaneous requests (pri=0).

Source files
------------

// File: rtl/addsub_arb_pkg.sv
// rtl/addsub_arb_pkg.sv - shared types and constants for the add/sub unit arbiter
//
// Word format is 31-bit sign-magnitude: bit SIGN_BIT is the sign, the bits
// below it are the magnitude. The controller only moves words around; it
// never interprets the sign.

package addsub_arb_pkg;

    localparam int SIGN_BIT = 30;
    localparam int WORD_W   = SIGN_BIT + 1;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/addsub_arb_rr.sv
// rtl/addsub_arb_rr.sv - two-way round-robin grant logic with priority flip on completion
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            grants may only be issued while enabled (controller idle)
//   req0, req1    request valid from requester 0 / 1
//   complete      one-cycle pulse when the current operation finishes
//   owner         requester that owns the finishing operation
//   gnt0, gnt1    combinational grants, at most one high

module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    input  logic complete,
    input  logic owner,
    output logic gnt0,
    output logic gnt1
);

    // pri names the requester that wins a tie.
    logic pri;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= 1'b0;
        end else if (complete) begin
            // The requester just served loses the next tie.
            pri <= ~owner;
        end
    end

    always_comb begin
        gnt0 = en && req0 && (!pri || !req1);
        gnt1 = en && req1 && ( pri || !req0);
    end

endmodule

// File: rtl/addsub_arb.sv
// rtl/addsub_arb.sv - shares one add unit and one sub unit between two requesters
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req0/1, op0/1, a0/1, b0/1    request, opcode (0 add, 1 sub = a - b), operands
//   gnt0/1                       combinational ready; accept on req & gnt at an edge
//   done0/1                      one-cycle completion pulse to the owner
//   res, ovf, err                result, overflow, timeout; held until the next done
//   busy                         high whenever an operation is in flight
//   add_start, sub_start         one-cycle start strobe to the selected unit
//   u_in1, u_in2                 operand buses shared by both units
//   add_stop/out/ovf             add unit response
//   sub_stop/out/ovf             sub unit response

module addsub_arb
    import addsub_arb_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req0,
    input  logic  op0,
    input  word_t a0,
    input  word_t b0,
    input  logic  req1,
    input  logic  op1,
    input  word_t a1,
    input  word_t b1,
    output logic  gnt0,
    output logic  gnt1,
    output logic  done0,
    output logic  done1,
    output word_t res,
    output logic  ovf,
    output logic  err,
    output logic  busy,
    output logic  add_start,
    output logic  sub_start,
    output word_t u_in1,
    output word_t u_in2,
    input  logic  add_stop,
    input  word_t add_out,
    input  logic  add_ovf,
    input  logic  sub_stop,
    input  word_t sub_out,
    input  logic  sub_ovf
);

    // WAIT gives up on the edge where the counter has already seen TIMEOUT-1
    // stop-less cycles, i.e. the TIMEOUT-th cycle spent in WAIT.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic          owner;
    op_t           op;
    logic [CW-1:0] cnt;

    logic  idle;
    logic  complete;
    logic  acc0;
    logic  acc1;
    op_t   new_op;
    word_t new_a;
    word_t new_b;
    logic  sel_stop;
    word_t sel_out;
    logic  sel_ovf;

    assign idle     = (state == ST_IDLE);
    assign complete = (state == ST_DONE);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (idle),
        .req0     (req0),
        .req1     (req1),
        .complete (complete),
        .owner    (owner),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    // Operands of whichever requester is being accepted this edge.
    always_comb begin
        acc0   = req0 && gnt0;
        acc1   = req1 && gnt1;
        new_op = acc1 ? op_t'(op1) : op_t'(op0);
        new_a  = acc1 ? a1 : a0;
        new_b  = acc1 ? b1 : b0;
    end

    // Only the unit that was started is listened to; the other unit's stop
    // is ignored so a stray response cannot complete the wrong operation.
    always_comb begin
        sel_stop = add_stop;
        sel_out  = add_out;
        sel_ovf  = add_ovf;
        if (op == OP_SUB) begin
            sel_stop = sub_stop;
            sel_out  = sub_out;
            sel_ovf  = sub_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            op        <= OP_ADD;
            cnt       <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            res       <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            add_start <= 1'b0;
            sub_start <= 1'b0;
            u_in1     <= '0;
            u_in2     <= '0;
        end else begin
            add_start <= 1'b0;
            sub_start <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (acc0 || acc1) begin
                        owner <= acc1;
                        op    <= new_op;
                        // Buses stay frozen until the next acceptance so the
                        // unit may sample them at any point up to its stop.
                        u_in1 <= new_a;
                        u_in2 <= new_b;
                        // Start is registered here so it is high for exactly
                        // the ISSUE cycle.
                        add_start <= (new_op == OP_ADD);
                        sub_start <= (new_op == OP_SUB);
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (sel_stop) begin
                        res   <= sel_out;
                        ovf   <= sel_ovf;
                        err   <= 1'b0;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        res   <= '0;
                        ovf   <= 1'b0;
                        err   <= 1'b1;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arb.sv
// tb/tb_addsub_arb.sv - randomized scoreboard bench for addsub_arb

module tb_addsub_arb;
    import addsub_arb_pkg::*;

    localparam int TIMEOUT = 15;
    localparam int CW      = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0  = 1'b0;
    logic        req1  = 1'b0;
    logic        op0   = 1'b0;
    logic        op1   = 1'b0;
    logic [30:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done0, done1, ovf, err, busy, add_start, sub_start;
    logic [30:0] res, u_in1, u_in2;
    logic        add_stop = 1'b0, add_ovf = 1'b0, sub_stop = 1'b0, sub_ovf = 1'b0;
    logic [30:0] add_out = '0, sub_out = '0;

    addsub_arb #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .ovf(ovf), .err(err), .busy(busy),
        .add_start(add_start), .sub_start(sub_start),
        .u_in1(u_in1), .u_in2(u_in2),
        .add_stop(add_stop), .add_out(add_out), .add_ovf(add_ovf),
        .sub_stop(sub_stop), .sub_out(sub_out), .sub_ovf(sub_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          owner;
        logic        op;
        logic [30:0] res;
        logic        ovf;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sign-magnitude arithmetic done on plain integers. A zero result keeps
    // the sign of a so that minus zero flows through the unit unchanged.
    function automatic logic [31:0] sm_calc(input logic op, input logic [30:0] a, input logic [30:0] b);
        longint va, vb, r, m;
        logic   neg;
        va = longint'(a[29:0]);
        vb = longint'(b[29:0]);
        if (a[30]) va = -va;
        if (b[30]) vb = -vb;
        r   = op ? (va - vb) : (va + vb);
        m   = (r < 0) ? -r : r;
        neg = (r < 0) || ((r == 0) && a[30]);
        return {(m >= (longint'(1) << 30)), neg, m[29:0]};
    endfunction

    function automatic logic [30:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 31'h00000000;
            1:       return 31'h3FFFFFFF;
            2:       return 31'h40000000;
            3:       return 31'h7FFFFFFF;
            default: return 31'($urandom);
        endcase
    endfunction

    // ---------------- behavioural add/sub units ----------------
    int delay_cfg = 0;
    bit stall     = 0;
    bit noise     = 0;
    bit pend      = 0;
    bit cur_sub   = 0;
    int pcnt      = 0;

    always @(negedge clk) begin
        if (rst_n && (add_start || sub_start)) begin
            pend    = 1;
            cur_sub = sub_start;
            pcnt    = delay_cfg;
        end
    end

    initial begin
        logic [31:0] r;
        forever begin
            @(posedge clk);
            #1;
            add_stop = 1'b0;
            sub_stop = 1'b0;
            add_out  = 31'($urandom);
            sub_out  = 31'($urandom);
            add_ovf  = 1'($urandom);
            sub_ovf  = 1'($urandom);
            if (pend && stall) begin
                pend = 0;
            end else if (pend) begin
                if (pcnt == 0) begin
                    r = sm_calc(cur_sub, u_in1, u_in2);
                    if (cur_sub) begin
                        sub_stop = 1'b1; sub_out = r[30:0]; sub_ovf = r[31];
                    end else begin
                        add_stop = 1'b1; add_out = r[30:0]; add_ovf = r[31];
                    end
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end
            // Spurious responses from the unit that was not started.
            if (noise && $urandom_range(0, 2) == 0) begin
                if (cur_sub) add_stop = 1'b1;
                else         sub_stop = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int tb_pri   = 0;
    int last_acc = -1;
    bit cont_chk = 0;

    always @(negedge clk) begin
        exp_t e;
        int   w, expw;
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                chk("gnt_exclusive", longint'(gnt0 && gnt1), 0);
                chk("gnt_while_busy", longint'(busy), 0);
            end
            if ((req0 && gnt0) || (req1 && gnt1)) begin
                w    = (req0 && gnt0) ? 0 : 1;
                expw = (req0 && req1) ? tb_pri : (req0 ? 0 : 1);
                chk("arb_owner", longint'(w), longint'(expw));
                if (cont_chk && req0 && req1 && last_acc >= 0)
                    chk("accept_gap", longint'(cyc - last_acc), 4);
                last_acc = cyc;
            end
            if (add_start || sub_start) begin
                chk("start_onehot", longint'(add_start && sub_start), 0);
                if (exp_q.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    chk("start_op", longint'(sub_start), longint'(exp_q[0].op));
                    chk("start_latency", longint'(cyc - exp_q[0].acc), 1);
                end
            end
            if (done0 || done1) begin
                chk("done_both", longint'(done0 && done1), 0);
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_owner", longint'(done1), longint'(e.owner));
                    chk("res", longint'(res), longint'(e.res));
                    chk("ovf", longint'(ovf), longint'(e.ovf));
                    chk("err", longint'(err), longint'(e.err));
                    chk("done_latency", longint'(cyc - e.acc), longint'(e.lat));
                    tb_pri = 1 - e.owner;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic drive(input int id, input logic op, input logic [30:0] a, input logic [30:0] b,
                         input logic [30:0] xres, input logic xovf);
        int   n;
        bit   got;
        exp_t e;
        n   = 0;
        got = 0;
        if (id == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else         begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        while (!got && n < 200) begin
            @(negedge clk);
            if ((id == 0) ? gnt0 : gnt1) got = 1;
            else n++;
        end
        if (got) begin
            e.owner = id;
            e.op    = op;
            e.err   = stall;
            e.res   = stall ? 31'h0 : xres;
            e.ovf   = stall ? 1'b0 : xovf;
            e.acc   = cyc;
            e.lat   = stall ? (TIMEOUT + 2) : (3 + delay_cfg);
            exp_q.push_back(e);
        end else begin
            chk("gnt_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic drive_rand(input int id);
        logic        op;
        logic [30:0] a, b;
        logic [31:0] r;
        op = 1'($urandom_range(0, 1));
        a  = rand_word();
        b  = rand_word();
        r  = sm_calc(op, a, b);
        drive(id, op, a, b, r[30:0], r[31]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",  longint'(busy), 0);
        chk("rst_res",   longint'(res), 0);
        chk("rst_flags", longint'({ovf, err, done0, done1}), 0);
        chk("rst_start", longint'({add_start, sub_start}), 0);
        chk("rst_uin",   longint'({u_in1, u_in2}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed cases
        drive(0, 1'b1, 31'd5, 31'd3, 31'h00000002, 1'b0);
        wait_idle();
        drive(1, 1'b0, 31'h3FFFFFFF, 31'h00000001, 31'h00000000, 1'b1);
        wait_idle();
        delay_cfg = 2;
        drive(0, 1'b1, 31'h40000005, 31'h00000003, 31'h40000008, 1'b0);
        wait_idle();
        delay_cfg = 0;
        drive(1, 1'b0, 31'h40000000, 31'h00000000, 31'h40000000, 1'b0);
        wait_idle();

        // timeout, then a normal op with noise on the idle unit
        stall = 1;
        noise = 1;
        drive(0, 1'b0, 31'd7, 31'd9, 31'd0, 1'b0);
        wait_idle();
        stall = 0;
        drive(1, 1'b1, 31'd100, 31'd1, 31'd99, 1'b0);
        wait_idle();

        // continuous load from both requesters
        cont_chk = 1;
        last_acc = -1;
        fork
            begin repeat (4) drive_rand(0); end
            begin repeat (4) drive_rand(1); end
        join
        wait_idle();
        cont_chk = 0;

        // random batches with varying unit latency
        for (int k = 0; k < 2; k++) begin
            delay_cfg = $urandom_range(0, 3);
            fork
                begin
                    for (int i = 0; i < 10; i++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        drive_rand(0);
                    end
                end
                begin
                    for (int j = 0; j < 10; j++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        drive_rand(1);
                    end
                end
            join
            wait_idle();
        end

        // reset in WAIT: leave pri at 1 first, then abort an op
        delay_cfg = 0;
        drive_rand(0);
        wait_idle();
        delay_cfg = 4;
        drive_rand(1);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        tb_pri = 0;
        #1;
        chk("abort_busy",  longint'(busy), 0);
        chk("abort_start", longint'({add_start, sub_start}), 0);
        chk("abort_done",  longint'({done0, done1}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        delay_cfg = 0;
        fork
            drive_rand(0);
            drive_rand(1);
        join
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
